// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/resource handshake bundle between the arbiter and its users.
interface mux4_rr_arbiter_if;

    logic [mux4_arb_pkg::NUM_REQ-1:0] req;
    logic                             done;
    logic [mux4_arb_pkg::NUM_REQ-1:0] gnt;
    logic [mux4_arb_pkg::SEL_W-1:0]   sel;
    logic                             busy;
    logic                             timeout_err;

    // Requesters and the shared resource drive req/done and observe the grant.
    modport master (
        output req, done,
        input  gnt, sel, busy, timeout_err
    );

    // The arbiter consumes req/done and produces the grant.
    modport slave (
        input  req, done,
        output gnt, sel, busy, timeout_err
    );

endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Rotating priority picker: first set req bit at or after ptr, wrapping.
module rr_priority_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any_valid,
    output logic [SEL_W-1:0]   winner
);

    logic [NUM_REQ-1:0][SEL_W-1:0] cand;
    logic [NUM_REQ-1:0]            hit;

    // cand[gi] is the index examined at search offset gi from the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign cand[gi] = ptr + SEL_W'(gi);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest search offset with a pending request wins.
    always_comb begin
        any_valid = |hit;
        winner    = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter holding each grant for a whole transaction, with
// release on done, requester abort or watchdog expiry.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
)(
    input  logic             clk,
    input  logic             rst,
    mux4_rr_arbiter_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg,   gnt_next;
    logic [SEL_W-1:0]   sel_reg,   sel_next;
    logic [SEL_W-1:0]   ptr_reg,   ptr_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;
    logic               terr_reg,  terr_next;

    logic [NUM_REQ-1:0] pick_req;
    logic [SEL_W-1:0]   pick_ptr;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_winner;
    logic               wd_hit;
    logic               release_now;

    // One picker serves both paths: in IDLE it searches from ptr; in BUSY it
    // searches from sel+1 with the releasing requester masked off.
    assign pick_req = (state_reg == BUSY) ? (bus.req & ~gnt_reg) : bus.req;
    assign pick_ptr = (state_reg == BUSY) ? (sel_reg + SEL_W'(1)) : ptr_reg;

    rr_priority_pick u_pick (
        .req       (pick_req),
        .ptr       (pick_ptr),
        .any_valid (pick_any),
        .winner    (pick_winner)
    );

    assign wd_hit      = (TIMEOUT > 0) && (cnt_reg == WD_LAST);
    assign release_now = bus.done || !bus.req[sel_reg] || wd_hit;

    // Next-state and grant logic.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        terr_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = BUSY;
                    gnt_next   = idx2onehot(pick_winner);
                    sel_next   = pick_winner;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_next  = sel_reg + SEL_W'(1);
                    cnt_next  = '0;
                    // Only a pure watchdog expiry is flagged; done or abort wins.
                    terr_next = wd_hit && !bus.done && bus.req[sel_reg];
                    if (pick_any) begin
                        gnt_next = idx2onehot(pick_winner);
                        sel_next = pick_winner;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else if (TIMEOUT > 0) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            terr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            terr_reg  <= terr_next;
        end
    end

    assign bus.gnt         = gnt_reg;
    assign bus.sel         = sel_reg;
    assign bus.busy        = (state_reg == BUSY);
    assign bus.timeout_err = terr_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (TIMEOUT=4).
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                             input logic e_busy, input logic e_terr);
        check({tag, ".gnt"},  8'(bus.gnt),         8'(e_gnt));
        check({tag, ".sel"},  8'(bus.sel),         8'(e_sel));
        check({tag, ".busy"}, 8'(bus.busy),        8'(e_busy));
        check({tag, ".terr"}, 8'(bus.timeout_err), 8'(e_terr));
        $display("step %-12s gnt=%b sel=%0d busy=%b terr=%b", tag, bus.gnt, bus.sel, bus.busy, bus.timeout_err);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        tick(); tick();
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // done while idle is ignored
        bus.done = 1'b1;
        tick();
        check_out("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.done = 1'b0;

        // Single requester, done three cycles after grant
        bus.req = 4'b0100;
        tick();
        check_out("single_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        check_out("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        bus.done = 1'b1;
        tick();
        check_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        bus.done = 1'b0;
        tick();
        check_out("single_again", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_out("single_abort", 4'b0000, 2'd2, 1'b0, 1'b0);

        // All four requesting, done every second cycle
        do_reset();
        bus.req = 4'b1111;
        tick();
        check_out("all_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        check_out("all_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.done = 1'b0;
        tick();
        check_out("all_h1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        check_out("all_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.done = 1'b0;
        tick();
        check_out("all_h2", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        check_out("all_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.done = 1'b0;
        tick();
        check_out("all_h3", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        check_out("all_g0b", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.done = 1'b0;

        // Rotation fairness between requesters 0 and 1
        do_reset();
        bus.req = 4'b0011;
        tick();
        check_out("fair_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        check_out("fair_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        check_out("fair_0b", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("fair_1b", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();
        check_out("fair_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Abort hands over to requester 3 at the same edge
        do_reset();
        bus.req = 4'b0010;
        tick();
        check_out("abort_gnt", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.req = 4'b0110;
        tick();
        check_out("abort_other", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.req = 4'b1000;
        tick();
        check_out("abort_b2b", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Reset while requester 3 holds the grant
        rst = 1'b1;
        tick();
        check_out("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.req = 4'b1001;
        tick();
        check_out("rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Watchdog: four BUSY cycles, then forced release
        do_reset();
        bus.req = 4'b0001;
        tick();
        check_out("wd_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("wd_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("wd_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("wd_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_out("wd_fire", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check_out("wd_regnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check_out("wd2_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        check_out("wd_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();
        check_out("end_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
